// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
//
// Purpose
//   EX->MEM pipeline register built from DEPTH back-to-back stages. Each stage
//   holds one instruction bundle: valid bit, writeback/memory controls,
//   destination register index, ALU result (effective address) and store data.
//   DEPTH > 1 adds retiming stages in front of a slow data-memory path.
//   Supports stall (all stages hold) and flush (stage 0 captures a bubble).
//
// Configuration
//   EX_MEM_FWD_EN  when defined, adds a forwarding-match unit and its ports
//                  (QueryRs, FwdHit, FwdData). When undefined, those ports and
//                  that logic are absent; the pipeline itself is identical.
//
// Parameters
//   DATA_W  width of the ALU result and store data paths
//   REG_W   width of the destination register index
//   DEPTH   number of register stages, 1..4
//
// Ports
//   Clock            in   rising-edge clock
//   Reset_n          in   synchronous reset, active low (overrides Stall/Flush)
//   Stall            in   1 = every stage holds (has priority over Flush)
//   Flush            in   1 = stage 0 captures a bubble instead of the inputs
//   ValidIn          in   input bundle carries a real instruction
//   RegWriteIn       in   writeback enable
//   MemToRegIn       in   writeback source select (1 = memory)
//   MemWriteIn       in   store size code (00 = none)
//   MemReadIn        in   load size code (00 = none)
//   WriteRegisterIn  in   destination register index
//   ALUResultIn      in   ALU result / effective address
//   ReadData2In      in   store data
//   *Out             out  bundle of the final stage (DEPTH-1), flop outputs
//   QueryRs          in   {Rs2,Rs1} of the instruction in EX      (FWD only)
//   FwdHit           out  per-query forwarding hit               (FWD only)
//   FwdData          out  {FwdData1,FwdData0} forwarded results  (FWD only)
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                ValidIn,
    input  logic                RegWriteIn,
    input  logic                MemToRegIn,
    input  logic [1:0]          MemWriteIn,
    input  logic [1:0]          MemReadIn,
    input  logic [REG_W-1:0]    WriteRegisterIn,
    input  logic [DATA_W-1:0]   ALUResultIn,
    input  logic [DATA_W-1:0]   ReadData2In,
    output logic                ValidOut,
    output logic                RegWriteOut,
    output logic                MemToRegOut,
    output logic [1:0]          MemWriteOut,
    output logic [1:0]          MemReadOut,
    output logic [REG_W-1:0]    WriteRegisterOut,
    output logic [DATA_W-1:0]   ALUResultOut,
    output logic [DATA_W-1:0]   ReadData2Out
`ifdef EX_MEM_FWD_EN
    ,
    input  logic [2*REG_W-1:0]  QueryRs,
    output logic [1:0]          FwdHit,
    output logic [2*DATA_W-1:0] FwdData
`endif
);

    // Reject unsupported depths at elaboration time.
    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("ex_mem_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [1:0]        mem_write;
        logic [1:0]        mem_read;
        logic [REG_W-1:0]  wr_reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];
    stage_t in_bundle;

    // A flushed slot and an invalid input are the same bubble: every field
    // is forced to zero, which is what makes the output controls qualified.
    always_comb begin
        in_bundle = '0;
        if (!Flush && ValidIn) begin
            in_bundle.valid      = 1'b1;
            in_bundle.reg_write  = RegWriteIn;
            in_bundle.mem_to_reg = MemToRegIn;
            in_bundle.mem_write  = MemWriteIn;
            in_bundle.mem_read   = MemReadIn;
            in_bundle.wr_reg     = WriteRegisterIn;
            in_bundle.alu        = ALUResultIn;
            in_bundle.rd2        = ReadData2In;
        end
    end

    // Next-state: Stall freezes the whole chain (a coincident Flush is
    // dropped; the hazard unit re-asserts it). Otherwise the chain shifts.
    always_comb begin
        stage_d[0] = Stall ? stage_q[0] : in_bundle;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = Stall ? stage_q[i] : stage_q[i-1];
        end
    end

    // ---- stage registers: reset clears data too so outputs read all-zero ----
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // ---- outputs: straight from the final stage flops ----
    assign ValidOut         = stage_q[DEPTH-1].valid;
    assign RegWriteOut      = stage_q[DEPTH-1].reg_write;
    assign MemToRegOut      = stage_q[DEPTH-1].mem_to_reg;
    assign MemWriteOut      = stage_q[DEPTH-1].mem_write;
    assign MemReadOut       = stage_q[DEPTH-1].mem_read;
    assign WriteRegisterOut = stage_q[DEPTH-1].wr_reg;
    assign ALUResultOut     = stage_q[DEPTH-1].alu;
    assign ReadData2Out     = stage_q[DEPTH-1].rd2;

`ifdef EX_MEM_FWD_EN
    // Forwarding match: scan youngest (stage 0) to oldest. The first stage
    // that writes the queried register decides the outcome; if that stage is
    // a load, its data is not ready yet, so older ALU matches are suppressed
    // and no hit is reported (the hazard unit stalls instead).
    logic [REG_W-1:0] rs_sel;
    logic             found;

    always_comb begin
        FwdHit  = '0;
        FwdData = '0;
        rs_sel  = '0;
        found   = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rs_sel = QueryRs[j*REG_W +: REG_W];
            found  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && stage_q[i].valid && stage_q[i].reg_write &&
                    (stage_q[i].wr_reg != '0) && (stage_q[i].wr_reg == rs_sel)) begin
                    found = 1'b1;
                    if (!stage_q[i].mem_to_reg) begin
                        FwdHit[j]                   = 1'b1;
                        FwdData[j*DATA_W +: DATA_W] = stage_q[i].alu;
                    end
                end
            end
        end
    end
`endif

endmodule
